bus_cycle_adapter: RTL and testbench

// Sits directly downstream of the 8088 core's external pins: demultiplexes AD/A, decodes
// ALE/RD_n/WR_n/IOM/INTA_n bus cycles and turns each into one request/acknowledge transaction
// on a simple system port (memory or I/O). Returns read data on inAD and paces the core via READY.

---
 rtl/bus_cycle_adapter.sv | 179 +++++++++++++++++
 tb/tb_bus_cycle_adapter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_adapter.sv
// rtl/bus_cycle_adapter.sv - 8088 pin-level bus cycle to system request/ack bridge
// Optional INTA_VECTOR_EN: two-phase interrupt acknowledge returning irq_vector on the second cycle.
module bus_cycle_adapter #(
    parameter int unsigned MIN_WAIT  = 0,
    parameter logic [7:0]  IDLE_DATA = 8'hFF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic [11:0] A,
    input  logic [7:0]  outAD,
    input  logic [7:0]  enAD,
    input  logic        RD_n,
    input  logic        WR_n,
    input  logic        IOM,
    input  logic        INTA_n,
    output logic [7:0]  inAD,
    output logic        READY,
    output logic [19:0] sys_addr,
    output logic        sys_io,
    output logic        sys_we,
    output logic [7:0]  sys_wdata,
    output logic        sys_req,
    input  logic        sys_ack,
    input  logic [7:0]  sys_rdata,
    input  logic [7:0]  irq_vector
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_REQ,
        S_WAIT,
        S_DELAY,
        S_HOLD
    } state_t;

    // The cycle that sees the completion event counts as the first extra wait cycle.
    localparam logic [3:0] WAIT_LOAD = (MIN_WAIT == 0) ? 4'd0 : 4'(MIN_WAIT - 1);

    state_t      state, state_n;
    logic        ready_n;
    logic [7:0]  in_ad_n;
    logic [19:0] addr_n;
    logic        io_n;
    logic        we_n;
    logic [7:0]  wdata_n;
    logic [3:0]  wait_cnt, wait_cnt_n;

`ifdef INTA_VECTOR_EN
    logic        phase, phase_n;
`else
    logic        unused_irq;
    assign unused_irq = ^irq_vector;
`endif

    assign sys_req = (state == S_REQ);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            READY     <= 1'b1;
            inAD      <= IDLE_DATA;
            sys_addr  <= 20'd0;
            sys_io    <= 1'b0;
            sys_we    <= 1'b0;
            sys_wdata <= 8'd0;
            wait_cnt  <= 4'd0;
`ifdef INTA_VECTOR_EN
            phase     <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            READY     <= ready_n;
            inAD      <= in_ad_n;
            sys_addr  <= addr_n;
            sys_io    <= io_n;
            sys_we    <= we_n;
            sys_wdata <= wdata_n;
            wait_cnt  <= wait_cnt_n;
`ifdef INTA_VECTOR_EN
            phase     <= phase_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        ready_n    = READY;
        in_ad_n    = inAD;
        addr_n     = sys_addr;
        io_n       = sys_io;
        we_n       = sys_we;
        wdata_n    = sys_wdata;
        wait_cnt_n = wait_cnt;
`ifdef INTA_VECTOR_EN
        phase_n    = phase;
`endif
        case (state)
            S_IDLE: begin
                if (ALE) begin
                    addr_n  = {A, outAD};
                    io_n    = IOM;
                    ready_n = 1'b0;
                    state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                // Read wins when both strobes are low.
                if (!RD_n) begin
                    we_n    = 1'b0;
                    state_n = S_REQ;
`ifdef INTA_VECTOR_EN
                    phase_n = 1'b0;
`endif
                end else if (!WR_n && enAD == 8'hFF) begin
                    wdata_n = outAD;
                    we_n    = 1'b1;
                    state_n = S_REQ;
`ifdef INTA_VECTOR_EN
                    phase_n = 1'b0;
`endif
                end else if (!INTA_n) begin
                    we_n = 1'b0;
`ifdef INTA_VECTOR_EN
                    in_ad_n = phase ? irq_vector : IDLE_DATA;
                    phase_n = ~phase;
                    if (MIN_WAIT == 0) begin
                        ready_n = 1'b1;
                        state_n = S_HOLD;
                    end else begin
                        wait_cnt_n = WAIT_LOAD;
                        state_n    = S_DELAY;
                    end
`else
                    in_ad_n = IDLE_DATA;
                    ready_n = 1'b1;
                    state_n = S_HOLD;
`endif
                end
            end
            S_REQ: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (sys_ack) begin
                    if (!sys_we) begin
                        in_ad_n = sys_rdata;
                    end
                    if (MIN_WAIT == 0) begin
                        ready_n = 1'b1;
                        state_n = S_HOLD;
                    end else begin
                        wait_cnt_n = WAIT_LOAD;
                        state_n    = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (wait_cnt == 4'd0) begin
                    ready_n = 1'b1;
                    state_n = S_HOLD;
                end else begin
                    wait_cnt_n = wait_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (RD_n && WR_n && INTA_n) begin
                    in_ad_n = IDLE_DATA;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_cycle_adapter.sv
// tb/tb_bus_cycle_adapter.sv - directed bench for bus_cycle_adapter at MIN_WAIT 0 and 3
module tb_bus_cycle_adapter;

    logic        clk = 1'b0;
    logic        rst, ale, rd_n, wr_n, iom, inta_n, ack;
    logic [11:0] a;
    logic [7:0]  out_ad, en_ad, rdata, irq;

    logic [7:0]  in_ad0, in_ad3, wdata0, wdata3;
    logic        ready0, ready3, io0, io3, we0, we3, req0, req3;
    logic [19:0] addr0, addr3;

    int tests = 0;
    int fails = 0;
    int low0, low3, nreq0, nreq3;

    always #5 clk = ~clk;

    bus_cycle_adapter #(.MIN_WAIT(0), .IDLE_DATA(8'hFF)) u0 (
        .CLK(clk), .RESET(rst), .ALE(ale), .A(a), .outAD(out_ad), .enAD(en_ad),
        .RD_n(rd_n), .WR_n(wr_n), .IOM(iom), .INTA_n(inta_n),
        .inAD(in_ad0), .READY(ready0), .sys_addr(addr0), .sys_io(io0), .sys_we(we0),
        .sys_wdata(wdata0), .sys_req(req0), .sys_ack(ack), .sys_rdata(rdata),
        .irq_vector(irq)
    );

    bus_cycle_adapter #(.MIN_WAIT(3), .IDLE_DATA(8'hFF)) u3 (
        .CLK(clk), .RESET(rst), .ALE(ale), .A(a), .outAD(out_ad), .enAD(en_ad),
        .RD_n(rd_n), .WR_n(wr_n), .IOM(iom), .INTA_n(inta_n),
        .inAD(in_ad3), .READY(ready3), .sys_addr(addr3), .sys_io(io3), .sys_we(we3),
        .sys_wdata(wdata3), .sys_req(req3), .sys_ack(ack), .sys_rdata(rdata),
        .irq_vector(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!ready0) low0++;
        if (!ready3) low3++;
        if (req0) nreq0++;
        if (req3) nreq3++;
    endtask

    // kind: 0 read, 1 write, 2 INTA, 3 read and write strobes together
    task automatic bus_cycle(input logic io, input logic [19:0] adr, input int kind,
                             input logic [7:0] wd, input int d, input logic [7:0] rd);
        low0 = 0; low3 = 0; nreq0 = 0; nreq3 = 0;
        ale = 1'b1; a = adr[19:8]; out_ad = adr[7:0]; iom = io; en_ad = 8'hFF;
        step();
        ale = 1'b0;
        case (kind)
            0: begin rd_n = 1'b0; en_ad = 8'h00; end
            1: begin wr_n = 1'b0; out_ad = wd; end
            2: begin inta_n = 1'b0; en_ad = 8'h00; end
            default: begin rd_n = 1'b0; wr_n = 1'b0; end
        endcase
        step();
        for (int e = 2; e < 40 && !(ready0 && ready3); e++) begin
            ack = (kind != 2) && (e == 3 + d);
            rdata = rd;
            step();
        end
        ack = 1'b0;
    endtask

    task automatic release_strobes();
        rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; iom = 1'b0; inta_n = 1'b1;
        ack = 1'b0; a = 12'h0; out_ad = 8'h0; en_ad = 8'h0; rdata = 8'h0; irq = 8'h08;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_ready", ready0, 1);
        check("rst_inad", in_ad0, 8'hFF);
        check("rst_req", req0, 0);
        check("rst_addr", addr0, 0);
        check("rst_we_io", {we0, io0}, 0);
        check("rst_wdata", wdata0, 0);

        // memory read, ack in first WAIT cycle
        bus_cycle(1'b0, 20'hFFFF0, 0, 8'h00, 0, 8'hEA);
        check("mr_low0", low0, 3);
        check("mr_low3", low3, 6);
        check("mr_req0", nreq0, 1);
        check("mr_req3", nreq3, 1);
        check("mr_addr", addr0, 20'hFFFF0);
        check("mr_we_io", {we0, io0}, 0);
        check("mr_inad0", in_ad0, 8'hEA);
        check("mr_inad3", in_ad3, 8'hEA);
        release_strobes();
        check("mr_idle_inad", in_ad0, 8'hFF);
        check("mr_idle_ready", ready0, 1);

        // I/O write, ack one cycle late
        bus_cycle(1'b1, 20'h00060, 1, 8'h5A, 1, 8'h00);
        check("iw_low0", low0, 4);
        check("iw_low3", low3, 7);
        check("iw_req0", nreq0, 1);
        check("iw_io_we", {io0, we0}, 2'b11);
        check("iw_wdata", wdata0, 8'h5A);
        check("iw_addr", addr3, 20'h00060);
        check("iw_inad", in_ad0, 8'hFF);
        release_strobes();

        // read with ack two cycles late; data must hold while RD_n stays low
        bus_cycle(1'b0, 20'h12345, 0, 8'h00, 2, 8'h3C);
        check("dr_low0", low0, 5);
        check("dr_low3", low3, 8);
        step(); step();
        check("dr_hold0", in_ad0, 8'h3C);
        check("dr_hold3", in_ad3, 8'h3C);
        release_strobes();
        check("dr_rel3", in_ad3, 8'hFF);

        // both strobes low resolves to a read
        bus_cycle(1'b0, 20'h00400, 3, 8'h00, 0, 8'hC3);
        check("rw_we", we0, 0);
        check("rw_inad", in_ad0, 8'hC3);
        release_strobes();

        // two INTA cycles
        bus_cycle(1'b0, 20'h00000, 2, 8'h00, 0, 8'h00);
        check("i1_inad0", in_ad0, 8'hFF);
        check("i1_inad3", in_ad3, 8'hFF);
        check("i1_req", nreq0 + nreq3, 0);
        check("i1_low0", low0, 1);
`ifdef INTA_VECTOR_EN
        check("i1_low3", low3, 4);
`else
        check("i1_low3", low3, 1);
`endif
        release_strobes();
        bus_cycle(1'b0, 20'h00000, 2, 8'h00, 0, 8'h00);
        check("i2_req", nreq0 + nreq3, 0);
`ifdef INTA_VECTOR_EN
        check("i2_inad0", in_ad0, 8'h08);
        check("i2_inad3", in_ad3, 8'h08);
`else
        check("i2_inad0", in_ad0, 8'hFF);
        check("i2_inad3", in_ad3, 8'hFF);
`endif
        release_strobes();

        // reset while waiting for ack, then a late ack
        ale = 1'b1; a = 12'hABC; out_ad = 8'hDE; iom = 1'b0;
        step();
        ale = 1'b0; rd_n = 1'b0; en_ad = 8'h00;
        step(); step();
        check("rw_pre_ready", ready0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0; ack = 1'b1; rdata = 8'h77;
        step();
        ack = 1'b0;
        check("rst_ack_ready0", ready0, 1);
        check("rst_ack_ready3", ready3, 1);
        check("rst_ack_inad0", in_ad0, 8'hFF);
        check("rst_ack_inad3", in_ad3, 8'hFF);
        check("rst_ack_addr", addr0, 0);
        release_strobes();
        check("rst_ack_idle", in_ad0, 8'hFF);

        // stray ack in IDLE
        ack = 1'b1; rdata = 8'h55;
        step();
        ack = 1'b0;
        step();
        check("stray_addr", addr0, 0);
        check("stray_ready", ready0, 1);
        check("stray_inad", in_ad0, 8'hFF);

        // ALE pulse while waiting must not relatch the address
        ale = 1'b1; a = 12'h111; out_ad = 8'h22; en_ad = 8'hFF;
        step();
        ale = 1'b0; rd_n = 1'b0; en_ad = 8'h00;
        step(); step();
        ale = 1'b1; a = 12'hFFF; out_ad = 8'hFF;
        step();
        ale = 1'b0;
        check("ale_wait_addr", addr0, 20'h11122);
        check("ale_wait_ready", ready0, 0);
        ack = 1'b1; rdata = 8'h99;
        step();
        ack = 1'b0;
        check("ale_wait_inad0", in_ad0, 8'h99);
        check("ale_wait_ready0", ready0, 1);
        for (int i = 0; i < 10 && !ready3; i++) step();
        check("ale_wait_ready3", ready3, 1);
        check("ale_wait_inad3", in_ad3, 8'h99);
        check("ale_wait_addr3", addr3, 20'h11122);
        release_strobes();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
